vm_coin_payer: RTL and testbench

Customer-side coin feeder for the vending machine. It drives the machine's `pi_money_one` and `pi_money_half` coin inputs from a latched coin budget, and consumes the machine's `po_beverage` and `po_money` responses. It repeats purchases while the budget still covers the price, and it checks every vend and change pulse against its own payment ledger. It sits in front of the machine in system-level benches and demo tops, in place of random coin stimulus.

---
 rtl/vm_coin_payer.sv | 112 +++++++++++
 tb/tb_vm_coin_payer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/vm_coin_payer.sv
// vm_coin_payer: feeds coins from a latched budget into the vending machine and
// repeats purchases while the budget lasts, checking every vend and change pulse.
module vm_coin_payer #(
  parameter int PRICE_HALF = 5,
  parameter int GAP        = 1,
  parameter int TIMEOUT    = 4,
  parameter int CNT_W      = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [3:0]       num_one,
  input  logic [3:0]       num_half,
  input  logic             po_beverage,
  input  logic             po_money,
  output logic             pi_money_one,
  output logic             pi_money_half,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] bev_cnt,
  output logic [CNT_W-1:0] change_cnt
);
  typedef enum logic [2:0] {IDLE, CHECK, COIN, GAP_WAIT, VEND_WAIT, FINISH} state_t;
  state_t     state;
  logic [3:0] ones, halves;
  logic [4:0] paid, pb, owed, paid_nxt;
  logic [5:0] value;
  logic [7:0] gcnt, tmr;
  logic       bought, pick_one, emit;
  // a purchase starts from zero paid, so CHECK picks its coin against an empty ledger
  always_comb begin
    pb       = (state == CHECK) ? '0 : paid;
    owed     = 5'(PRICE_HALF) - pb;
    pick_one = (owed >= 5'd2 && ones != 4'd0) || halves == 4'd0;
    paid_nxt = pb + (pick_one ? 5'd2 : 5'd1);
    value    = {1'b0, ones, 1'b0} + {2'b0, halves};
    emit     = (state == CHECK && value >= 6'(PRICE_HALF)) ||
               (state == COIN && paid < 5'(PRICE_HALF) && GAP == 0) ||
               (state == GAP_WAIT && gcnt == 8'(GAP - 1));
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      ones          <= '0;
      halves        <= '0;
      paid          <= '0;
      gcnt          <= '0;
      tmr           <= '0;
      bought        <= 1'b0;
      pi_money_one  <= 1'b0;
      pi_money_half <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      bev_cnt       <= '0;
      change_cnt    <= '0;
    end else begin
      pi_money_one  <= emit && pick_one;
      pi_money_half <= emit && !pick_one;
      done          <= 1'b0;
      if (emit) begin
        paid <= paid_nxt;
        if (pick_one) ones <= ones - 4'd1;
        else halves <= halves - 4'd1;
      end
      case (state)
        IDLE: if (start) begin
          ones   <= num_one;
          halves <= num_half;
          err    <= 1'b0;
          busy   <= 1'b1;
          bought <= 1'b0;
          state  <= CHECK;
        end
        CHECK: if (emit) state <= COIN;
        else begin
          if (!bought) err <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FINISH;
        end
        COIN: if (paid >= 5'(PRICE_HALF)) begin
          tmr   <= '0;
          state <= VEND_WAIT;
        end else if (GAP != 0) begin
          gcnt  <= '0;
          state <= GAP_WAIT;
        end
        GAP_WAIT: if (emit) state <= COIN;
        else gcnt <= gcnt + 8'd1;
        VEND_WAIT: if (po_beverage) begin
          bev_cnt <= bev_cnt + CNT_W'(1);
          if (po_money) change_cnt <= change_cnt + CNT_W'(1);
          if (po_money != (paid == 5'(PRICE_HALF + 1))) err <= 1'b1;
          bought <= 1'b1;
          state  <= CHECK;
        end else begin
          if (po_money) err <= 1'b1;
          if (tmr == 8'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else tmr <= tmr + 8'd1;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vm_coin_payer.sv
// tb_vm_coin_payer: plays the vending machine against vm_coin_payer and checks
// coin order, coin timing, session end, error flag and counters against a purchase model.
module tb_vm_coin_payer;
  localparam int P  = 5;
  localparam int G  = 1;
  localparam int TO = 4;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_one = '0, num_half = '0;
  logic       po_beverage = 1'b0, po_money = 1'b0;
  logic       pi_money_one, pi_money_half, busy, done, err;
  logic [7:0] bev_cnt, change_cnt;
  int         passed = 0, total = 0;
  int         bev_m = 0, chg_m = 0;
  vm_coin_payer #(.PRICE_HALF(P), .GAP(G), .TIMEOUT(TO), .CNT_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .num_one(num_one),
    .num_half(num_half), .po_beverage(po_beverage), .po_money(po_money),
    .pi_money_one(pi_money_one), .pi_money_half(pi_money_half), .busy(busy),
    .done(done), .err(err), .bev_cnt(bev_cnt), .change_cnt(change_cnt)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  // f: 0 = well-behaved machine, 1 = never vends, 2 = change pulse inverted
  task automatic run_session(input int o, input int h, input int f);
    int q[$], per[$], pay[$];
    int oo, hh, pd, n, pi, k, next_coin, vend_at, last_coin, done_exp, extra, overlap;
    bit finished, chg;
    oo = o; hh = h;
    while (2 * oo + hh >= P) begin
      pd = 0; n = 0;
      while (pd < P) begin
        if (P - pd >= 2 && oo > 0) begin q.push_back(1); oo--; pd += 2; end
        else if (hh > 0) begin q.push_back(0); hh--; pd += 1; end
        else begin q.push_back(1); oo--; pd += 2; end
        n++;
      end
      per.push_back(n); pay.push_back(pd);
      if (f == 1) break;
    end
    pi = 0; k = 0; next_coin = 2; vend_at = -1; last_coin = -1; extra = 0; overlap = 0;
    done_exp = (per.size() == 0) ? 2 : -1;
    finished = 0;
    @(negedge sys_clk);
    start = 1'b1; num_one = 4'(o); num_half = 4'(h);
    for (int t = 1; t < 600 && !finished; t++) begin
      @(posedge sys_clk); #1;
      start = (t == 1);
      if (t == 1) chk("busy_after_start", busy, 1);
      if (pi_money_one && pi_money_half) overlap++;
      if (pi_money_one || pi_money_half) begin
        if (q.size() == 0) extra++;
        else begin
          chk("coin_type", pi_money_one, q.pop_front());
          chk("coin_time", t, next_coin);
          k++;
          if (k == per[pi]) begin
            vend_at = t + $urandom_range(1, TO);
            last_coin = t;
          end else next_coin = t + G + 1;
        end
      end
      po_beverage = 1'b0; po_money = 1'b0;
      if (t == vend_at) begin
        vend_at = -1;
        if (f == 1) done_exp = last_coin + TO + 1;
        else begin
          chg = (pay[pi] == P + 1) ^ (f == 2);
          po_beverage = 1'b1; po_money = chg;
          bev_m++; chg_m += int'(chg);
          pi++; k = 0; next_coin = t + 2;
          if (pi == per.size()) done_exp = t + 2;
        end
      end
      if (done) begin
        chk("done_time", t, done_exp);
        chk("busy_at_done", busy, 0);
        finished = 1;
      end
    end
    po_beverage = 1'b0; po_money = 1'b0; start = 1'b0;
    if (!finished) chk("session_timeout", 0, 1);
    chk("err", err, (per.size() == 0 || f != 0) ? 1 : 0);
    chk("bev_cnt", bev_cnt, bev_m % 256);
    chk("change_cnt", change_cnt, chg_m % 256);
    chk("coins_missing", q.size(), 0);
    chk("coins_extra", extra, 0);
    chk("coin_overlap", overlap, 0);
    repeat (3) begin
      @(posedge sys_clk); #1;
      chk("idle_quiet", {busy, done, pi_money_one, pi_money_half}, 0);
    end
  endtask
  initial begin
    int c;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outputs", {pi_money_one, pi_money_half, busy, done, err, bev_cnt, change_cnt}, 0);
    sys_rst_n = 1'b1;
    run_session(2, 1, 0);
    run_session(3, 0, 0);
    run_session(4, 2, 0);
    run_session(1, 2, 0);
    run_session(2, 1, 1);
    run_session(2, 1, 2);
    @(negedge sys_clk);
    start = 1'b1; num_one = 4'd2; num_half = 4'd1;
    c = 0;
    for (int t = 0; t < 10 && c == 0; t++) begin
      @(posedge sys_clk); #1;
      start = 1'b0;
      if (pi_money_one || pi_money_half) c = 1;
    end
    chk("first_coin_before_reset", c, 1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("midrun_reset_outputs", {pi_money_one, pi_money_half, busy, done, err, bev_cnt, change_cnt}, 0);
    bev_m = 0; chg_m = 0;
    c = 0;
    repeat (2) begin @(posedge sys_clk); #1; c += int'(pi_money_one | pi_money_half); end
    sys_rst_n = 1'b1;
    repeat (4) begin @(posedge sys_clk); #1; c += int'(pi_money_one | pi_money_half | busy); end
    chk("no_coins_after_reset", c, 0);
    run_session(2, 1, 0);
    for (int i = 0; i < 25; i++)
      run_session($urandom_range(0, 15), $urandom_range(0, 15),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
